// File: rtl/xfft_frame_ctrl.sv
// rtl/xfft_frame_ctrl.sv - one-frame sequencer for the xfft core: config word, N-sample load, drain monitor.
// Optional drain watchdog enabled by defining XFFT_CTRL_TIMEOUT_EN.

module xfft_frame_ctrl #(
  parameter int N_LOG2 = 10,
  parameter int SCH_W  = 10,
  parameter int TMO_W  = 16
) (
  input  logic             aclk,
  input  logic             rst,
  input  logic             start,
  input  logic             fwd_inv,
  input  logic [SCH_W-1:0] scale_sch,
  output logic             busy,
  output logic             frame_done,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [15:0]      frame_cnt,
  input  logic [31:0]      src_tdata,
  input  logic             src_tvalid,
  output logic             src_tready,
  output logic [15:0]      cfg_tdata,
  output logic             cfg_tvalid,
  input  logic             cfg_tready,
  output logic [31:0]      fft_tdata,
  output logic             fft_tvalid,
  input  logic             fft_tready,
  output logic             fft_tlast,
  input  logic             mon_tvalid,
  input  logic             mon_tready,
  input  logic             mon_tlast,
  input  logic             ev_tlast_unexpected,
  input  logic             ev_tlast_missing
);

  typedef enum logic [1:0] {S_IDLE, S_CONFIG, S_LOAD, S_DRAIN} state_e;

  state_e              state_q;
  logic [N_LOG2-1:0]   in_cnt_q;
  logic [N_LOG2-1:0]   out_cnt_q;
  logic [15:0]         cfg_tdata_q;
  logic                cfg_tvalid_q;
  logic                done_q;
  logic                err_q;
  logic [2:0]          err_code_q;
  logic [15:0]         frame_cnt_q;
  logic [15:0]         cfg_word_d;
  logic                in_load;
  logic                in_fire;
  logic                out_fire;
  logic                ev_any;
`ifdef XFFT_CTRL_TIMEOUT_EN
  logic [TMO_W-1:0]    tmo_q;
`endif

  assign cfg_word_d = 16'({scale_sch, fwd_inv});
  assign in_load    = (state_q == S_LOAD);
  assign in_fire    = in_load & src_tvalid & fft_tready;
  assign out_fire   = mon_tvalid & mon_tready;
  assign ev_any     = ev_tlast_unexpected | ev_tlast_missing;

  // Load phase is a zero-latency wire-through gated by state.
  assign fft_tdata  = in_load ? src_tdata : '0;
  assign fft_tvalid = in_load & src_tvalid;
  assign src_tready = in_load & fft_tready;
  assign fft_tlast  = in_load & (&in_cnt_q);

  assign busy       = (state_q != S_IDLE);
  assign frame_done = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign frame_cnt  = frame_cnt_q;
  assign cfg_tdata  = cfg_tdata_q;
  assign cfg_tvalid = cfg_tvalid_q;

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      cfg_tdata_q  <= '0;
      cfg_tvalid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= '0;
      frame_cnt_q  <= '0;
`ifdef XFFT_CTRL_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cfg_tdata_q  <= cfg_word_d;
            cfg_tvalid_q <= 1'b1;
            err_code_q   <= '0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            state_q      <= S_CONFIG;
          end
        end
        S_CONFIG: begin
          if (cfg_tready) begin
            cfg_tvalid_q <= 1'b0;
            state_q      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (ev_any) begin
            err_code_q <= err_code_q | {1'b0, ev_tlast_missing, ev_tlast_unexpected};
            err_q      <= 1'b1;
            state_q    <= S_IDLE;
          end else if (in_fire) begin
            if (&in_cnt_q) begin
              state_q <= S_DRAIN;
`ifdef XFFT_CTRL_TIMEOUT_EN
              tmo_q   <= '0;
`endif
            end else begin
              in_cnt_q <= in_cnt_q + N_LOG2'(1);
            end
          end
        end
        S_DRAIN: begin
          // Events take priority over a simultaneously completing output beat.
          if (ev_any) begin
            err_code_q <= err_code_q | {1'b0, ev_tlast_missing, ev_tlast_unexpected};
            err_q      <= 1'b1;
            state_q    <= S_IDLE;
          end else if (out_fire) begin
            if (mon_tlast && (&out_cnt_q)) begin
              done_q      <= 1'b1;
              frame_cnt_q <= frame_cnt_q + 16'd1;
              state_q     <= S_IDLE;
            end else if (mon_tlast || (&out_cnt_q)) begin
              err_code_q[2] <= 1'b1;
              err_q         <= 1'b1;
              state_q       <= S_IDLE;
            end else begin
              out_cnt_q <= out_cnt_q + N_LOG2'(1);
            end
`ifdef XFFT_CTRL_TIMEOUT_EN
            tmo_q <= '0;
          end else if (&tmo_q) begin
            err_code_q[2] <= 1'b1;
            err_q         <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xfft_frame_ctrl.sv
// tb/tb_xfft_frame_ctrl.sv - randomized frame-level bench for xfft_frame_ctrl with an outcome model.

module tb_xfft_frame_ctrl;

  localparam int N_LOG2 = 3;
  localparam int N      = 8;
  localparam int SCH_W  = 10;
  localparam int TMO_W  = 4;

  logic             aclk = 1'b0;
  logic             rst;
  logic             start;
  logic             fwd_inv;
  logic [SCH_W-1:0] scale_sch;
  logic             busy;
  logic             frame_done;
  logic             err;
  logic [2:0]       err_code;
  logic [15:0]      frame_cnt;
  logic [31:0]      src_tdata;
  logic             src_tvalid;
  logic             src_tready;
  logic [15:0]      cfg_tdata;
  logic             cfg_tvalid;
  logic             cfg_tready;
  logic [31:0]      fft_tdata;
  logic             fft_tvalid;
  logic             fft_tready;
  logic             fft_tlast;
  logic             mon_tvalid;
  logic             mon_tready;
  logic             mon_tlast;
  logic             ev_tlast_unexpected;
  logic             ev_tlast_missing;

  xfft_frame_ctrl #(.N_LOG2(N_LOG2), .SCH_W(SCH_W), .TMO_W(TMO_W)) dut (
    .aclk(aclk), .rst(rst), .start(start), .fwd_inv(fwd_inv), .scale_sch(scale_sch),
    .busy(busy), .frame_done(frame_done), .err(err), .err_code(err_code), .frame_cnt(frame_cnt),
    .src_tdata(src_tdata), .src_tvalid(src_tvalid), .src_tready(src_tready),
    .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready),
    .fft_tdata(fft_tdata), .fft_tvalid(fft_tvalid), .fft_tready(fft_tready), .fft_tlast(fft_tlast),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
    .ev_tlast_unexpected(ev_tlast_unexpected), .ev_tlast_missing(ev_tlast_missing)
  );

  always #5 aclk = ~aclk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_frames = 0;
  logic [2:0]  exp_code = 3'b000;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; fwd_inv = 0; scale_sch = '0;
    src_tdata = '0; src_tvalid = 0; cfg_tready = 0; fft_tready = 0;
    mon_tvalid = 0; mon_tready = 0; mon_tlast = 0;
    ev_tlast_unexpected = 0; ev_tlast_missing = 0;
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_busy"}, busy, 0);
    check_eq({pfx, "_done"}, frame_done, 0);
    check_eq({pfx, "_err"}, err, 0);
    check_eq({pfx, "_code"}, err_code, 0);
    check_eq({pfx, "_fcnt"}, frame_cnt, 0);
    check_eq({pfx, "_cfgv"}, cfg_tvalid, 0);
    check_eq({pfx, "_cfgd"}, cfg_tdata, 0);
    check_eq({pfx, "_srdy"}, src_tready, 0);
    check_eq({pfx, "_fval"}, fft_tvalid, 0);
    check_eq({pfx, "_flast"}, fft_tlast, 0);
    check_eq({pfx, "_fdata"}, fft_tdata, 0);
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1;
    cyc();
    cyc();
    rst = 0;
    fft_tready = 1;
    src_tvalid = 1;
    src_tdata = 32'hDEAD_BEEF;
    #3;
    exp_frames = 0;
    exp_code = 0;
    check_all_zero("rst");
    src_tvalid = 0;
  endtask

  task automatic start_frame(input logic fwd, input logic [SCH_W-1:0] sch, input int stall);
    logic [31:0] word;
    word = (32'(sch) << 1) | 32'(fwd);
    cyc();
    start = 1; fwd_inv = fwd; scale_sch = sch; fft_tready = 1;
    cyc();
    start = 0; fwd_inv = 1'($urandom); scale_sch = SCH_W'($urandom);
    #3;
    exp_code = 0;
    check_eq("cfg_valid", cfg_tvalid, 1);
    check_eq("cfg_word", cfg_tdata, word);
    check_eq("start_clr_code", err_code, 0);
    check_eq("cfg_busy", busy, 1);
    check_eq("cfg_srdy_gated", src_tready, 0);
    for (int k = 0; k < stall; k++) begin
      cyc();
      #3;
      check_eq("cfg_hold_v", cfg_tvalid, 1);
      check_eq("cfg_hold_d", cfg_tdata, word);
    end
    cyc();
    cfg_tready = 1;
    cyc();
    cfg_tready = 0;
    #3;
    check_eq("cfg_drop", cfg_tvalid, 0);
    check_eq("load_busy", busy, 1);
  endtask

  task automatic load_frame(input bit plan, input int ev_at, input int rst_at, output bit aborted);
    logic [31:0] samp [N];
    int idx, budget;
    bit tog, hs, ev_hit, rst_hit;
    aborted = 0;
    for (int i = 0; i < N; i++) samp[i] = plan ? 32'h0001_0000 * (i + 1) : $urandom;
    idx = 0; budget = 0; tog = 0;
    while (idx < N && budget < 200) begin
      cyc();
      budget++;
      tog = ~tog;
      src_tvalid = plan ? tog : 1'($urandom_range(0, 1));
      fft_tready = plan ? 1'b1 : ($urandom_range(0, 3) != 0);
      src_tdata  = src_tvalid ? samp[idx] : $urandom;
      hs = src_tvalid && fft_tready;
      ev_hit  = hs && (idx == ev_at);
      rst_hit = hs && (idx == rst_at);
      ev_tlast_missing = ev_hit;
      rst = rst_hit;
      #3;
      check_eq("pass_valid", fft_tvalid, src_tvalid);
      check_eq("pass_ready", src_tready, fft_tready);
      if (hs) begin
        check_eq("pass_data", fft_tdata, samp[idx]);
        check_eq("pass_last", fft_tlast, idx == N - 1);
        idx++;
      end
      if (ev_hit || rst_hit) begin
        cyc();
        ev_tlast_missing = 0; rst = 0; src_tvalid = 0;
        #3;
        if (ev_hit) begin
          exp_code = 3'b010;
          check_eq("ev_err", err, 1);
          check_eq("ev_code", err_code, exp_code);
          check_eq("ev_idle", busy, 0);
          check_eq("ev_fcnt", frame_cnt, exp_frames);
          cyc();
          #3;
          check_eq("ev_err_pulse", err, 0);
        end else begin
          exp_frames = 0;
          exp_code = 0;
          check_all_zero("midrst");
        end
        aborted = 1;
        return;
      end
    end
    if (idx != N) check_eq("load_budget", idx, N);
    cyc();
    src_tvalid = 1; fft_tready = 1;
    #3;
    check_eq("post_srdy", src_tready, 0);
    check_eq("post_fval", fft_tvalid, 0);
    check_eq("drain_busy", busy, 1);
    src_tvalid = 0;
  endtask

  // Outcome model: frame ends at beat min(tlast_pos, N); clean only for tlast exactly on beat N.
  task automatic drain_frame(input int tlast_pos, input bit ev_final);
    int beats, budget, end_beat;
    bit ok, hs, first;
    end_beat = (tlast_pos < N) ? tlast_pos : N;
    ok = (tlast_pos == N) && !ev_final;
    beats = 0; budget = 0; first = 1;
    while (beats < end_beat && budget < 300) begin
      cyc();
      budget++;
      start = first;
      first = 0;
      mon_tvalid = ($urandom_range(0, 3) != 0);
      mon_tready = 1'($urandom_range(0, 1));
      hs = mon_tvalid && mon_tready;
      mon_tlast = mon_tvalid && (beats + 1 == tlast_pos);
      ev_tlast_unexpected = hs && ev_final && (beats + 1 == end_beat);
      #3;
      check_eq("drain_done_lo", frame_done, 0);
      check_eq("drain_err_lo", err, 0);
      check_eq("drain_busy", busy, 1);
      check_eq("drain_no_cfg", cfg_tvalid, 0);
      if (hs) beats++;
    end
    if (beats != end_beat) check_eq("drain_budget", beats, end_beat);
    cyc();
    start = 0; mon_tvalid = 0; mon_tready = 0; mon_tlast = 0; ev_tlast_unexpected = 0;
    #3;
    if (ok) exp_frames = (exp_frames + 1) & 32'hFFFF;
    else exp_code = exp_code | (ev_final ? 3'b001 : 3'b100);
    check_eq("end_done", frame_done, ok);
    check_eq("end_err", err, !ok);
    check_eq("end_code", err_code, exp_code);
    check_eq("end_fcnt", frame_cnt, exp_frames);
    check_eq("end_busy", busy, 0);
    check_eq("end_cfgv", cfg_tvalid, 0);
    cyc();
    #3;
    check_eq("end_done_pulse", frame_done, 0);
    check_eq("end_err_pulse", err, 0);
    check_eq("end_fcnt_hold", frame_cnt, exp_frames);
  endtask

  task automatic full_frame(input bit plan, input int tlast_pos, input bit ev_final);
    bit ab;
    start_frame(1'($urandom), SCH_W'($urandom), $urandom_range(0, 3));
    load_frame(plan, -1, -1, ab);
    if (!ab) drain_frame(tlast_pos, ev_final);
  endtask

  initial begin
    bit ab;
    reset_dut();

    start_frame(1'b1, 10'h2AA, 3);
    load_frame(1, -1, -1, ab);
    drain_frame(N, 0);
    full_frame(0, N, 0);

    start_frame(1'b0, 10'h155, 1);
    load_frame(0, 4, -1, ab);
    start_frame(1'b1, 10'h3FF, 0);
    load_frame(0, -1, -1, ab);
    drain_frame(6, 0);

    full_frame(0, N, 1);
    full_frame(0, N + 1, 0);
    full_frame(0, 1, 0);

    for (int f = 0; f < 6; f++)
      full_frame(0, $urandom_range(1, N + 1), ($urandom_range(0, 3) == 0));

    start_frame(1'b1, 10'h0F0, 0);
    load_frame(1, -1, 3, ab);
    full_frame(0, N, 0);

`ifdef XFFT_CTRL_TIMEOUT_EN
    begin
      int waited;
      start_frame(1'b1, 10'h001, 0);
      load_frame(0, -1, -1, ab);
      waited = 0;
      while (err !== 1'b1 && waited < 40) begin
        cyc();
        #3;
        waited++;
      end
      check_eq("tmo_err", err, 1);
      check_eq("tmo_code", err_code, 3'b100);
      check_eq("tmo_idle", busy, 0);
      check_eq("tmo_fcnt", frame_cnt, exp_frames);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xfft_frame_ctrl.md
Name: xfft_frame_ctrl

Overview:
- Sequences one FFT frame at a time through the xfft core: issues the run-time config word, then forwards exactly 2^N_LOG2 input samples from an upstream AXI-Stream source with a generated tlast.
- Monitors the core's output handshake for frame completion and its event pins for errors.
- Sits between the sample producer / software control and the FFT core wrapper; output data itself flows directly from the core to the sink.

Parameters:
- N_LOG2, 10, log2 of transform length; frame length N = 2^N_LOG2.
- SCH_W, 10, width of the scaling schedule field in the config word.
- TMO_W, 16, width of the drain watchdog counter (used only with the optional feature).

Ports:
- aclk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse; begin a frame
- fwd_inv  in  1  1 = forward, 0 = inverse; sampled on start
- scale_sch  in  SCH_W  scaling schedule; sampled on start
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse when the output frame's last beat handshakes
- err  out  1  one-cycle pulse when a frame aborts
- err_code  out  3  sticky: bit0 tlast_unexpected, bit1 tlast_missing, bit2 output length/timeout; cleared by start
- frame_cnt  out  16  completed frames, wraps 0xFFFF->0
- src_tdata  in  32  upstream samples {im[15:0], re[15:0]}
- src_tvalid  in  1  upstream valid
- src_tready  out  1  upstream ready
- cfg_tdata  out  16  to core config: {zero pad, scale_sch, fwd_inv}; fwd_inv at bit0
- cfg_tvalid  out  1  config valid
- cfg_tready  in  1  core config ready
- fft_tdata  out  32  to core data input
- fft_tvalid  out  1  core input valid
- fft_tready  in  1  core input ready
- fft_tlast  out  1  core input last
- mon_tvalid  in  1  tap of core m_axis_data_tvalid
- mon_tready  in  1  tap of sink m_axis_data_tready
- mon_tlast  in  1  tap of core m_axis_data_tlast
- ev_tlast_unexpected  in  1  core event
- ev_tlast_missing  in  1  core event

Behaviour:
- Reset: state IDLE; all outputs 0 (busy, frame_done, err, err_code, frame_cnt, cfg_tvalid, src_tready, fft_tvalid, fft_tlast, cfg_tdata). Reset mid-frame aborts immediately with no err pulse; the core is not reconfigured until the next start.
- FSM states: IDLE, CONFIG, LOAD, DRAIN.
- IDLE: on start, register fwd_inv/scale_sch, clear err_code, clear in/out counters, go to CONFIG next cycle. start in any other state is ignored.
- CONFIG: cfg_tvalid=1 with the registered word, held stable until cfg_tready; on handshake go to LOAD with cfg_tvalid=0 the next cycle.
- LOAD: combinational pass-through. fft_tdata=src_tdata, fft_tvalid=src_tvalid, src_tready=fft_tready; no data buffering, zero latency.
  - in_cnt (N_LOG2 bits) increments on each fft_tvalid&fft_tready; fft_tlast=1 when in_cnt==N-1.
  - The handshake of the N-th beat moves to DRAIN; src_tready=0 outside LOAD.
- DRAIN: out_cnt increments on mon_tvalid&mon_tready.
  - Beat with mon_tlast and out_cnt==N-1: pulse frame_done, increment frame_cnt, go to IDLE.
  - mon_tlast at any other count, or N beats without tlast: set err_code[2], pulse err, go to IDLE.
- Events: ev_tlast_unexpected or ev_tlast_missing high in LOAD or DRAIN sets the matching err_code bit, pulses err, and goes to IDLE on the next cycle. Events in IDLE/CONFIG are ignored.
- Simultaneous event and completing beat: error wins; no frame_done, frame_cnt unchanged.
- frame_done and err are registered, one cycle after the triggering handshake/event; busy drops in the same cycle they assert.

Optional Feature:
- Macro XFFT_CTRL_TIMEOUT_EN.
- Defined: TMO_W-bit counter clears on DRAIN entry and on every output beat, increments otherwise. Reaching all-ones sets err_code[2], pulses err, returns to IDLE.
- Undefined: no counter; DRAIN waits indefinitely; TMO_W is unused.

Test Plan (N_LOG2=3, N=8):
- Reset then idle: all outputs 0, busy=0; start with fwd_inv=1, scale_sch=0x2AA -> cfg_tdata=0x0555, cfg_tvalid held through 3 cycles of cfg_tready=0, drops one cycle after handshake.
- Stream 8 samples 0x00010000..0x00080000 with src_tvalid toggling every other cycle -> fft_tdata matches, fft_tlast only on 8th beat, src_tready=0 after it.
- Core model returns 8 output beats with tlast on 8th and mon_tready throttled 50% -> single frame_done pulse, frame_cnt=1, busy=0; a second frame -> frame_cnt=2.
- Pulse ev_tlast_missing during LOAD at beat 5 -> err pulse, err_code=3'b010, state IDLE; next start clears err_code to 0.
- Output tlast at beat 6 -> err, err_code[2]=1, frame_cnt unchanged; assert rst at beat 4 of a LOAD -> all outputs 0 next cycle, no err.
- With XFFT_CTRL_TIMEOUT_EN, TMO_W=4: no output beats for 15 cycles in DRAIN -> err pulse, err_code=3'b100.
